// File: rtl/stack_pkg.sv
// Shared types and constants for the hardware LIFO stack and its instruction decoder.
package stack_pkg;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_ACTIVE = 2'd1,
        S_FULL   = 2'd2
    } stack_state_t;

    // Instruction prefix the write-back mux uses to select stack data.
    localparam logic [6:0] STACK_OPCODE = 7'b1111110;

endpackage

// File: rtl/stack_unit_if.sv
// Command/status bundle between the stack unit and its controller.
interface stack_unit_if #(
    parameter int D_WIDTH = 34,
    parameter int A_WIDTH = 4
);
    logic               push_i;
    logic               pop_i;
    logic               clear_i;
    logic [D_WIDTH-1:0] push_data_i;
    logic [D_WIDTH-1:0] stack_data_o;
    logic [A_WIDTH:0]   count_o;
    logic               empty_o;
    logic               full_o;
    logic               overflow_o;
    logic               underflow_o;

    modport master (
        output push_i, pop_i, clear_i, push_data_i,
        input  stack_data_o, count_o, empty_o, full_o, overflow_o, underflow_o
    );

    modport slave (
        input  push_i, pop_i, clear_i, push_data_i,
        output stack_data_o, count_o, empty_o, full_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/stack_mem.sv
// DEPTH x D_WIDTH register array: one synchronous write port, one combinational read port.
module stack_mem #(
    parameter int D_WIDTH = 34,
    parameter int DEPTH   = 16,
    parameter int A_WIDTH = 4
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [A_WIDTH-1:0] waddr_i,
    input  logic [D_WIDTH-1:0] wdata_i,
    input  logic [A_WIDTH-1:0] raddr_i,
    output logic [D_WIDTH-1:0] rdata_o
);
    logic [D_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/stack_unit.sv
// LIFO stack with registered top-of-stack, occupancy FSM and sticky overflow/underflow flags.
module stack_unit
    import stack_pkg::*;
#(
    parameter int D_WIDTH = 34,
    parameter int DEPTH   = 16,
    parameter int A_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    stack_unit_if.slave  bus
);
    localparam logic [A_WIDTH:0]   CNT_ONE  = (A_WIDTH+1)'(1);
    localparam logic [A_WIDTH:0]   CNT_LAST = (A_WIDTH+1)'(DEPTH-1);
    localparam logic [A_WIDTH-1:0] IDX_ONE  = A_WIDTH'(1);
    localparam logic [A_WIDTH-1:0] IDX_TWO  = A_WIDTH'(2);

    stack_state_t       state_q, state_d;
    logic [A_WIDTH:0]   count_q, count_d;
    logic [D_WIDTH-1:0] tos_q, tos_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic               mem_we;
    logic [A_WIDTH-1:0] mem_waddr;
    logic [A_WIDTH-1:0] mem_raddr;
    logic [D_WIDTH-1:0] mem_rdata;

    stack_mem #(
        .D_WIDTH (D_WIDTH),
        .DEPTH   (DEPTH),
        .A_WIDTH (A_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (bus.push_data_i),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    // Entry just below the current top; low bits wrap harmlessly when count == DEPTH.
    assign mem_raddr = count_q[A_WIDTH-1:0] - IDX_TWO;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tos_d     = tos_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        mem_we    = 1'b0;
        mem_waddr = count_q[A_WIDTH-1:0];

        if (bus.clear_i) begin
            state_d = S_EMPTY;
            count_d = '0;
            tos_d   = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (bus.push_i && bus.pop_i && state_q != S_EMPTY) begin
            // Replace top in place: occupancy and state are unchanged.
            mem_we    = 1'b1;
            mem_waddr = count_q[A_WIDTH-1:0] - IDX_ONE;
            tos_d     = bus.push_data_i;
        end else if (bus.push_i) begin
            if (state_q == S_FULL) begin
                ovf_d = 1'b1;
            end else begin
                mem_we  = 1'b1;
                tos_d   = bus.push_data_i;
                count_d = count_q + CNT_ONE;
                state_d = (count_q == CNT_LAST) ? S_FULL : S_ACTIVE;
            end
        end else if (bus.pop_i) begin
            if (state_q == S_EMPTY) begin
                unf_d = 1'b1;
            end else if (count_q == CNT_ONE) begin
                count_d = '0;
                tos_d   = '0;
                state_d = S_EMPTY;
            end else begin
                count_d = count_q - CNT_ONE;
                tos_d   = mem_rdata;
                state_d = S_ACTIVE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            count_q <= '0;
            tos_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tos_q   <= tos_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.stack_data_o = tos_q;
    assign bus.count_o      = count_q;
    assign bus.empty_o      = (state_q == S_EMPTY);
    assign bus.full_o       = (state_q == S_FULL);
    assign bus.overflow_o   = ovf_q;
    assign bus.underflow_o  = unf_q;
endmodule
